// File: rtl/fwft_small_fifo.sv
`default_nettype none
// ============================================================================
// Module   : fwft_small_fifo
// Brief    : First-word-fall-through FIFO for AXI-Stream beats; head entry
//            is always on dout while non-empty, rd_en pops it.
// Revision : 1.0
// ============================================================================
module fwft_small_fifo #(
   parameter int WIDTH               = 72,
   parameter int MAX_DEPTH_BITS      = 2,
   parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
   input  logic             axis_aclk,
   input  logic             axis_resetn,
   input  logic [WIDTH-1:0] din,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             nearly_full,
   output logic             prog_full,
   output logic             empty
);

   localparam int C_DEPTH = 2**MAX_DEPTH_BITS;
   localparam logic [MAX_DEPTH_BITS:0] C_CNT_FULL  = (MAX_DEPTH_BITS+1)'(C_DEPTH);
   localparam logic [MAX_DEPTH_BITS:0] C_CNT_NFULL = (MAX_DEPTH_BITS+1)'(C_DEPTH - 1);
   localparam logic [MAX_DEPTH_BITS:0] C_CNT_PROG  = (MAX_DEPTH_BITS+1)'(PROG_FULL_THRESHOLD);
   localparam logic [MAX_DEPTH_BITS:0] C_CNT_ONE   = (MAX_DEPTH_BITS+1)'(1);
   localparam logic [MAX_DEPTH_BITS-1:0] C_PTR_ONE = MAX_DEPTH_BITS'(1);

   logic [WIDTH-1:0]          r_mem [C_DEPTH];
   logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
   logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
   logic [MAX_DEPTH_BITS:0]   r_count;

   logic w_rd_acc;
   logic w_wr_acc;

   // A full FIFO still accepts a write when the head is popped in the same cycle.
   assign w_rd_acc = rd_en && !empty;
   assign w_wr_acc = wr_en && (!full || w_rd_acc);

   always_ff @(posedge axis_aclk) begin
      if (!axis_resetn) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
         end
         if (w_wr_acc && !w_rd_acc) begin
            r_count <= r_count + C_CNT_ONE;
         end else if (w_rd_acc && !w_wr_acc) begin
            r_count <= r_count - C_CNT_ONE;
         end
      end
   end

   // Storage is deliberately not reset; the pointers alone define validity.
   always_ff @(posedge axis_aclk) begin
      if (axis_resetn && w_wr_acc) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   assign empty       = (r_count == '0);
   assign full        = (r_count == C_CNT_FULL);
   assign nearly_full = (r_count >= C_CNT_NFULL);
   assign prog_full   = (r_count >= C_CNT_PROG);
   assign dout        = empty ? '0 : r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: tb/tb_fwft_small_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwft_small_fifo
// Brief    : Directed vector table plus streaming sequence for fwft_small_fifo.
// Revision : 1.0
// ============================================================================
module tb_fwft_small_fifo;

   localparam int C_W = 8;

   logic           axis_aclk = 1'b0;
   logic           axis_resetn;
   logic [C_W-1:0] din;
   logic           wr_en;
   logic           rd_en;
   logic [C_W-1:0] dout;
   logic           full;
   logic           nearly_full;
   logic           prog_full;
   logic           empty;

   int n_checks = 0;
   int n_errors = 0;

   fwft_small_fifo #(
      .WIDTH               (C_W),
      .MAX_DEPTH_BITS      (2),
      .PROG_FULL_THRESHOLD (3)
   ) dut (
      .axis_aclk   (axis_aclk),
      .axis_resetn (axis_resetn),
      .din         (din),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .dout        (dout),
      .full        (full),
      .nearly_full (nearly_full),
      .prog_full   (prog_full),
      .empty       (empty)
   );

   always #5 axis_aclk = ~axis_aclk;

   typedef struct {
      logic           rstn;
      logic           wr;
      logic           rd;
      logic [C_W-1:0] d;
      logic           e;
      logic           f;
      logic           nf;
      logic           pf;
      logic [C_W-1:0] q;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic rstn, logic wr, logic rd, logic [C_W-1:0] d,
                               logic e, logic f, logic nf, logic pf, logic [C_W-1:0] q);
      vec_t v;
      v = '{rstn, wr, rd, d, e, f, nf, pf, q};
      vecs.push_back(v);
   endfunction

   task automatic check(string name, logic e, logic f, logic nf, logic pf, logic [C_W-1:0] q);
      n_checks++;
      if ({empty, full, nearly_full, prog_full, dout} !== {e, f, nf, pf, q}) begin
         n_errors++;
         $display("FAIL %s: got empty=%0b full=%0b nf=%0b pf=%0b dout=%h, expected empty=%0b full=%0b nf=%0b pf=%0b dout=%h",
                  name, empty, full, nearly_full, prog_full, dout, e, f, nf, pf, q);
      end
   endtask

   task automatic step(logic rstn, logic wr, logic rd, logic [C_W-1:0] d);
      axis_resetn = rstn;
      wr_en       = wr;
      rd_en       = rd;
      din         = d;
      @(posedge axis_aclk);
      #1;
   endtask

   initial begin
      axis_resetn = 1'b0;
      wr_en       = 1'b0;
      rd_en       = 1'b0;
      din         = '0;

      //   rstn wr rd din     e  f  nf pf dout
      add(0, 0, 0, 8'h00,  1, 0, 0, 0, 8'h00);  // reset
      add(1, 0, 0, 8'h00,  1, 0, 0, 0, 8'h00);  // idle
      add(1, 1, 0, 8'hA1,  0, 0, 0, 0, 8'hA1);  // A
      add(1, 1, 0, 8'hB2,  0, 0, 0, 0, 8'hA1);  // B
      add(1, 1, 0, 8'hC3,  0, 0, 1, 1, 8'hA1);  // C -> 3 entries
      add(1, 1, 0, 8'hD4,  0, 1, 1, 1, 8'hA1);  // D -> full
      add(1, 1, 0, 8'hE5,  0, 1, 1, 1, 8'hA1);  // E dropped
      add(1, 0, 1, 8'h00,  0, 0, 1, 1, 8'hB2);
      add(1, 0, 1, 8'h00,  0, 0, 0, 0, 8'hC3);
      add(1, 0, 1, 8'h00,  0, 0, 0, 0, 8'hD4);
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);  // drained; E never stored
      add(1, 1, 0, 8'hA1,  0, 0, 0, 0, 8'hA1);
      add(1, 1, 0, 8'hB2,  0, 0, 0, 0, 8'hA1);
      add(1, 1, 0, 8'hC3,  0, 0, 1, 1, 8'hA1);
      add(1, 1, 0, 8'hD4,  0, 1, 1, 1, 8'hA1);
      add(1, 1, 1, 8'hE5,  0, 1, 1, 1, 8'hB2);  // pop A, push E while full
      add(1, 0, 1, 8'h00,  0, 0, 1, 1, 8'hC3);
      add(1, 0, 1, 8'h00,  0, 0, 0, 0, 8'hD4);
      add(1, 0, 1, 8'h00,  0, 0, 0, 0, 8'hE5);
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);  // read while empty x3
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);
      add(1, 1, 1, 8'h77,  0, 0, 0, 0, 8'h77);  // no bypass: X shows next cycle
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);  // X popped
      add(1, 1, 0, 8'h31,  0, 0, 0, 0, 8'h31);
      add(1, 1, 0, 8'h32,  0, 0, 0, 0, 8'h31);
      add(1, 1, 0, 8'h33,  0, 0, 1, 1, 8'h31);
      add(0, 1, 0, 8'h99,  1, 0, 0, 0, 8'h00);  // reset beats write
      add(1, 1, 0, 8'h5A,  0, 0, 0, 0, 8'h5A);  // Y
      add(1, 0, 1, 8'h00,  1, 0, 0, 0, 8'h00);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rstn, vecs[i].wr, vecs[i].rd, vecs[i].d);
         check($sformatf("vec%0d", i), vecs[i].e, vecs[i].f, vecs[i].nf, vecs[i].pf, vecs[i].q);
      end

      // Streaming: one write and one read every cycle from empty, wraps the pointers.
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b1, 1'b1, C_W'(i));
         check($sformatf("stream%0d", i), 1'b0, 1'b0, 1'b0, 1'b0, C_W'(i));
      end
      step(1'b1, 1'b0, 1'b1, 8'h00);
      check("stream_drain", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 1'b0, 8'h00);
      check("final_idle", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
